// File: rtl/dlx_mem_pkg.sv
// Shared types and helpers for the data-memory port.
// Big-endian lane numbering: lane 0 holds bits [0:7].
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_t;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    function automatic logic [0:3] lane_mask(
        input mem_size_t  size,
        input logic [0:1] lo
    );
        logic [0:3] m;
        m = 4'b0000;
        unique case (size)
            SZ_BYTE: m[lo] = 1'b1;
            SZ_HALF: m = lo[0] ? 4'b0011 : 4'b1100;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering: load extract with sign/zero extend (STORE=0),
// or store-data replication across lanes (STORE=1).
module dmem_lane_align
    import dlx_mem_pkg::*;
#(
    parameter bit STORE = 1'b0
) (
    input  mem_size_t   size,
    input  logic [0:1]  lane,
    input  logic        sext,
    input  logic [0:31] data_in,
    output logic [0:31] data_out
);

    logic [0:BYTE_W-1] b;
    logic [0:HALF_W-1] h;
    logic [0:WORD_W-1] ext;
    logic [0:WORD_W-1] rep;

    always_comb begin
        b   = data_in[{lane, 3'b000} +: BYTE_W];
        h   = lane[0] ? data_in[16:31] : data_in[0:15];
        ext = data_in;
        rep = data_in;
        unique case (size)
            SZ_BYTE: begin
                ext = {{24{sext & b[0]}}, b};
                rep = {4{data_in[24:31]}};
            end
            SZ_HALF: begin
                ext = {{16{sext & h[0]}}, h};
                rep = {2{data_in[16:31]}};
            end
            default: begin
                ext = data_in;
                rep = data_in;
            end
        endcase
        data_out = STORE ? rep : ext;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: word array, posted one-entry store buffer
// with load forwarding, sticky fault flags and a store counter.
module dmem_responder
    import dlx_mem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:31] addr_to_mem,
    input  logic        write_enable_to_mem,
    input  logic        byte_to_mem,
    input  logic        half_word_to_mem,
    input  logic        sign_extend_to_mem,
    input  logic [0:31] data_to_mem,
    output logic [0:31] data_from_mem,
    output logic        misaligned,
    output logic        out_of_range,
    output logic [0:31] err_addr,
    output logic [0:15] wr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [0:31] LIMIT = 32'd4 << DEPTH_LOG2;

    logic [0:31] mem [DEPTH];

    logic [0:31]           off;
    logic [DEPTH_LOG2-1:0] idx;
    mem_size_t             size;
    logic                  aligned;
    logic                  in_range;
    logic                  ok;
    logic [0:31]           arr_word;
    logic [0:31]           view;
    logic [0:31]           ld_word;
    logic [0:31]           st_word;

    logic                  pend_valid;
    logic [DEPTH_LOG2-1:0] pend_idx;
    logic [0:3]            pend_mask;
    logic [0:31]           pend_data;

    assign off      = addr_to_mem - BASE_ADDR;
    assign idx      = off[30-DEPTH_LOG2:29];
    assign in_range = off < LIMIT;
    assign size     = byte_to_mem      ? SZ_BYTE :
                      half_word_to_mem ? SZ_HALF : SZ_WORD;

    always_comb begin
        aligned = 1'b1;
        unique case (size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~addr_to_mem[31];
            default: aligned = addr_to_mem[30:31] == 2'b00;
        endcase
    end

    assign ok       = aligned & in_range;
    assign arr_word = mem[idx];

    // Pending store overlays the array so loads see it a cycle early
    always_comb begin
        view = arr_word;
        for (int k = 0; k < 4; k++) begin
            if (pend_valid && pend_idx == idx && pend_mask[k])
                view[k*8 +: 8] = pend_data[k*8 +: 8];
        end
    end

    dmem_lane_align #(.STORE(1'b0)) u_load (
        .size     (size),
        .lane     (addr_to_mem[30:31]),
        .sext     (sign_extend_to_mem),
        .data_in  (view),
        .data_out (ld_word)
    );

    dmem_lane_align #(.STORE(1'b1)) u_store (
        .size     (size),
        .lane     (addr_to_mem[30:31]),
        .sext     (1'b0),
        .data_in  (data_to_mem),
        .data_out (st_word)
    );

    assign data_from_mem = ok ? ld_word : 32'h0;

    always_ff @(posedge clock) begin
        if (pend_valid) begin
            for (int k = 0; k < 4; k++) begin
                if (pend_mask[k])
                    mem[pend_idx][k*8 +: 8] <= pend_data[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid   <= 1'b0;
            pend_idx     <= '0;
            pend_mask    <= 4'b0000;
            pend_data    <= 32'h0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
            err_addr     <= 32'h0;
            wr_count     <= 16'h0;
        end else begin
            if (pend_valid && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            if (write_enable_to_mem && ok) begin
                pend_valid <= 1'b1;
                pend_idx   <= idx;
                pend_mask  <= lane_mask(size, addr_to_mem[30:31]);
                pend_data  <= st_word;
            end else begin
                pend_valid <= 1'b0;
            end
            if (write_enable_to_mem && !ok) begin
                if (!misaligned && !out_of_range)
                    err_addr <= addr_to_mem;
                if (!aligned)
                    misaligned <= 1'b1;
                if (!in_range)
                    out_of_range <= 1'b1;
            end
        end
    end

endmodule
